// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: CSRRW/CSRRS/CSRRC access, trap state,
// 64-bit mcycle/minstret counters and illegal-access detection.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter int          COUNTER_EN  = 1,
  parameter int          SCRATCH_NUM = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic        instret_inc,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  logic        mie, mpie;
  logic [31:0] mtvec, mepc, mcause, mtval;
  logic [31:0] mscratch [SCRATCH_NUM];
  logic [63:0] mcycle, minstret;

  logic [31:0]            mstatus_rd;
  logic [31:0]            rd_val;
  logic                   impl;
  logic [SCRATCH_NUM-1:0] scr_hit;
  logic                   write_try;
  logic                   read_only;
  logic                   illegal;
  logic                   csr_we;
  logic [31:0]            wr_data;

  // MPP is hard-wired to machine mode; only MIE and MPIE are stored.
  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin : decode
    rd_val  = '0;
    impl    = 1'b1;
    scr_hit = '0;
    case (csr_addr)
      CSR_MSTATUS:   rd_val = mstatus_rd;
      CSR_MTVEC:     rd_val = mtvec;
      CSR_MEPC:      rd_val = mepc;
      CSR_MCAUSE:    rd_val = mcause;
      CSR_MTVAL:     rd_val = mtval;
      CSR_MCYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH:   rd_val = mcycle[63:32];
      CSR_MINSTRET:  rd_val = minstret[31:0];
      CSR_MINSTRETH: rd_val = minstret[63:32];
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:    rd_val = '0;
      CSR_MHARTID:   rd_val = HART_ID;
      default: begin
        // Extra scratch slots overlapping mepc/mcause/mtval are shadowed by
        // the named cases above and therefore never reachable.
        impl = 1'b0;
        for (int i = 0; i < SCRATCH_NUM; i++) begin
          if (csr_addr == CSR_MSCRATCH + 12'(i)) begin
            impl       = 1'b1;
            rd_val     = mscratch[i];
            scr_hit[i] = 1'b1;
          end
        end
      end
    endcase
  end

  // RS/RC with a zero operand is a pure read: no write attempt, no side effect.
  assign write_try = (op == OP_RW) || ((op != OP_NONE) && (csr_wdata != '0));
  assign read_only = (csr_addr[11:10] == 2'b11);
  assign illegal   = (op != OP_NONE) && (!impl || (read_only && write_try));
  assign csr_we    = write_try && !illegal && !trap_valid && !mret_valid;

  assign csr_illegal = illegal;
  assign csr_rdata   = (op != OP_NONE) ? rd_val : '0;

  always_comb begin : write_value
    case (op)
      OP_RW:   wr_data = csr_wdata;
      OP_RS:   wr_data = rd_val | csr_wdata;
      OP_RC:   wr_data = rd_val & ~csr_wdata;
      default: wr_data = rd_val;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mtvec  <= MTVEC_RST & ~32'd3;
      mepc   <= '0;
      mcause <= '0;
      mtval  <= '0;
    end else if (trap_valid) begin
      mepc   <= trap_pc & ~32'd3;
      mcause <= trap_cause;
      mtval  <= trap_tval;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_valid) begin
      mie    <= mpie;
      mpie   <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie  <= wr_data[3];
          mpie <= wr_data[7];
        end
        CSR_MTVEC:  mtvec  <= wr_data & ~32'd3;
        CSR_MEPC:   mepc   <= wr_data & ~32'd3;
        CSR_MCAUSE: mcause <= wr_data;
        CSR_MTVAL:  mtval  <= wr_data;
        default: ;
      endcase
    end
  end

  // NOTE: the scratch array is a handful of flops, so it is reset like any
  // other register rather than treated as an unreset RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SCRATCH_NUM; i++) mscratch[i] <= '0;
    end else begin
      for (int i = 0; i < SCRATCH_NUM; i++) begin
        if (csr_we && scr_hit[i]) mscratch[i] <= wr_data;
      end
    end
  end

  generate
    if (COUNTER_EN != 0) begin : g_cnt
      logic [63:0] mcycle_nxt, minstret_nxt;

      // A CSR write to one half replaces that counter's increment; the other
      // half holds its old value with no carry.
      always_comb begin
        mcycle_nxt   = mcycle + 64'd1;
        minstret_nxt = minstret + 64'(instret_inc);
        if (csr_we) begin
          case (csr_addr)
            CSR_MCYCLE:    mcycle_nxt   = {mcycle[63:32], wr_data};
            CSR_MCYCLEH:   mcycle_nxt   = {wr_data, mcycle[31:0]};
            CSR_MINSTRET:  minstret_nxt = {minstret[63:32], wr_data};
            CSR_MINSTRETH: minstret_nxt = {wr_data, minstret[31:0]};
            default: ;
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mcycle   <= '0;
          minstret <= '0;
        end else begin
          mcycle   <= mcycle_nxt;
          minstret <= minstret_nxt;
        end
      end
    end else begin : g_no_cnt
      assign mcycle   = '0;
      assign minstret = '0;
    end
  endgenerate

  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;
  assign mie_o   = mie;

endmodule
